// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core-to-memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned DEF_BIT_WIDTH   = 32;
  localparam int unsigned DEF_MAX_DSTREAK = 4;
  localparam int unsigned DEF_TIMEOUT     = 16;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IBUSY = 2'b01,
    ST_DBUSY = 2'b10
  } state_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Watchdog counter: cleared while idle, counts busy cycles, flags the last allowed cycle.
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TIMEOUT - 1));

  // Holds at the terminal count; the arbiter leaves BUSY on that cycle anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// data first with a bounded streak, one transaction at a time, with a watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c_ireq,
  input  logic [BIT_WIDTH-1:0] c_iad,
  output logic [BIT_WIDTH-1:0] c_idt,
  output logic                 c_acki_n,
  input  logic                 c_mreq,
  input  logic                 c_write,
  input  logic [1:0]           c_size,
  input  logic [BIT_WIDTH-1:0] c_dad,
  input  logic [BIT_WIDTH-1:0] c_wdata,
  output logic [BIT_WIDTH-1:0] c_rdata,
  output logic                 c_ackd_n,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n,
  output logic                 bus_err
);

  localparam int unsigned DW = $clog2(MAX_DSTREAK + 1);

  state_t        state;
  logic [DW-1:0] dstreak;
  logic          busy;
  logic          expire;
  logic          grant_d;
  logic          grant_i;
  logic          in_ibusy;
  logic          in_dbusy;
  logic          mem_ack;

  // Data wins a tie unless it has already taken MAX_DSTREAK grants past a waiting fetch.
  assign grant_d  = c_mreq && !(c_ireq && (dstreak == DW'(MAX_DSTREAK)));
  assign grant_i  = c_ireq && !grant_d;
  assign busy     = (state != ST_IDLE);
  assign in_ibusy = (state == ST_IBUSY);
  assign in_dbusy = (state == ST_DBUSY);
  assign mem_ack  = !m_ack_n;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy),
    .en     (busy),
    .expire (expire)
  );

  // Core acks follow the memory ack combinationally; a timeout acks with zero data.
  assign c_acki_n = !(in_ibusy && (mem_ack || expire));
  assign c_ackd_n = !(in_dbusy && (mem_ack || expire));
  assign c_idt    = (in_ibusy && mem_ack) ? m_rdata : '0;
  assign c_rdata  = (in_dbusy && mem_ack) ? m_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      dstreak <= '0;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= SIZE_WORD;
      m_addr  <= '0;
      m_wdata <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state   <= ST_DBUSY;
            m_req   <= 1'b1;
            m_write <= c_write;
            m_size  <= c_size;
            m_addr  <= c_dad;
            m_wdata <= c_wdata;
            if (!c_ireq) begin
              dstreak <= '0;
            end else if (dstreak != DW'(MAX_DSTREAK)) begin
              dstreak <= dstreak + DW'(1);
            end
          end else if (grant_i) begin
            state   <= ST_IBUSY;
            m_req   <= 1'b1;
            m_write <= 1'b0;
            m_size  <= SIZE_WORD;
            m_addr  <= c_iad;
            m_wdata <= '0;
            dstreak <= '0;
          end
        end
        ST_IBUSY, ST_DBUSY: begin
          if (mem_ack || expire) begin
            state <= ST_IDLE;
            m_req <= 1'b0;
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch/data arbitration, streak limit, watchdog, reset.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        c_ireq;
  logic [31:0] c_iad;
  logic [31:0] c_idt;
  logic        c_acki_n;
  logic        c_mreq;
  logic        c_write;
  logic [1:0]  c_size;
  logic [31:0] c_dad;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_ackd_n;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack_n;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .c_ireq   (c_ireq),
    .c_iad    (c_iad),
    .c_idt    (c_idt),
    .c_acki_n (c_acki_n),
    .c_mreq   (c_mreq),
    .c_write  (c_write),
    .c_size   (c_size),
    .c_dad    (c_dad),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .c_ackd_n (c_ackd_n),
    .m_req    (m_req),
    .m_write  (m_write),
    .m_size   (m_size),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack_n  (m_ack_n),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called 1ns after an edge with requests set up and the arbiter idle.
  // Runs one granted transaction acked in its first BUSY cycle.
  task automatic txn(input string tag, input logic exp_d, input logic [31:0] exp_addr,
                     input logic exp_wr, input logic [1:0] exp_size,
                     input logic [31:0] exp_wd, input logic [31:0] rdata);
    @(posedge clk); #1;
    check({tag, ".m_req"},   32'(m_req),   32'd1);
    check({tag, ".m_addr"},  m_addr,       exp_addr);
    check({tag, ".m_write"}, 32'(m_write), 32'(exp_wr));
    check({tag, ".m_size"},  32'(m_size),  32'(exp_size));
    check({tag, ".m_wdata"}, m_wdata,      exp_wd);
    m_rdata = rdata;
    m_ack_n = 1'b0;
    #1;
    check({tag, ".acki_n"},  32'(c_acki_n), 32'(exp_d));
    check({tag, ".ackd_n"},  32'(c_ackd_n), 32'(!exp_d));
    check({tag, ".c_idt"},   c_idt,         exp_d ? 32'h0 : rdata);
    check({tag, ".c_rdata"}, c_rdata,       exp_d ? rdata : 32'h0);
    @(posedge clk); #1;
    m_ack_n = 1'b1;
    check({tag, ".m_req_drop"}, 32'(m_req), 32'd0);
  endtask

  logic seq_d [6];

  initial begin
    rst = 1'b0; c_ireq = 1'b0; c_iad = '0; c_mreq = 1'b0; c_write = 1'b0;
    c_size = 2'b00; c_dad = '0; c_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;
    seq_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst.m_req",    32'(m_req),    32'd0);
    check("rst.m_addr",   m_addr,        32'd0);
    check("rst.m_wdata",  m_wdata,       32'd0);
    check("rst.m_size",   32'(m_size),   32'd0);
    check("rst.acki_n",   32'(c_acki_n), 32'd1);
    check("rst.ackd_n",   32'(c_ackd_n), 32'd1);
    check("rst.bus_err",  32'(bus_err),  32'd0);
    rst = 1'b1;

    // Memory ack while idle is ignored
    @(posedge clk); #1;
    m_rdata = 32'h1234_5678;
    m_ack_n = 1'b0;
    #1;
    check("idle_ack.acki_n", 32'(c_acki_n), 32'd1);
    check("idle_ack.ackd_n", 32'(c_ackd_n), 32'd1);
    check("idle_ack.c_idt",  c_idt,         32'd0);
    @(posedge clk); #1;
    m_ack_n = 1'b1;
    check("idle_ack.m_req", 32'(m_req), 32'd0);

    // Fetch only
    c_ireq = 1'b1; c_iad = 32'h100;
    txn("fetch", 1'b0, 32'h100, 1'b0, 2'b00, 32'h0, 32'h2400_0001);
    c_ireq = 1'b0;

    // Simultaneous load and fetch: data first, then fetch
    c_ireq = 1'b1; c_iad = 32'h300;
    c_mreq = 1'b1; c_write = 1'b0; c_size = 2'b00; c_dad = 32'h40; c_wdata = 32'h0;
    txn("tie.d", 1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 32'hAAAA_0040);
    c_mreq = 1'b0;
    txn("tie.i", 1'b0, 32'h300, 1'b0, 2'b00, 32'h0, 32'hBBBB_0300);
    c_ireq = 1'b0;

    // Continuous contention: D,D,D,D,I,D
    c_ireq = 1'b1; c_iad = 32'h300;
    c_mreq = 1'b1; c_write = 1'b0; c_dad = 32'h200; c_wdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      txn($sformatf("streak%0d", i), seq_d[i], seq_d[i] ? 32'h200 : 32'h300,
          1'b0, 2'b00, seq_d[i] ? 32'h55 : 32'h0, 32'h1000 + 32'(i));
    end
    c_ireq = 1'b0; c_mreq = 1'b0;

    // Watchdog: memory never acks a load
    c_mreq = 1'b1; c_write = 1'b0; c_size = 2'b00; c_dad = 32'h80; c_wdata = 32'h0;
    m_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("wdog.m_req",  32'(m_req), 32'd1);
    check("wdog.m_addr", m_addr,     32'h80);
    check("wdog.ackd_c1", 32'(c_ackd_n), 32'd1);
    for (int i = 2; i <= 15; i++) begin
      @(posedge clk); #1;
      check($sformatf("wdog.ackd_c%0d", i), 32'(c_ackd_n), 32'd1);
    end
    @(posedge clk); #1;
    check("wdog.ackd_c16", 32'(c_ackd_n), 32'd0);
    check("wdog.acki_c16", 32'(c_acki_n), 32'd1);
    check("wdog.rdata",    c_rdata,       32'd0);
    c_mreq = 1'b0;
    @(posedge clk); #1;
    check("wdog.bus_err", 32'(bus_err), 32'd1);
    check("wdog.m_req",   32'(m_req),   32'd0);
    check("wdog.ackd_off", 32'(c_ackd_n), 32'd1);

    // Byte store to stdout address; bus_err stays sticky
    c_mreq = 1'b1; c_write = 1'b1; c_size = 2'b10; c_dad = 32'hF000_0000; c_wdata = 32'h41;
    txn("store", 1'b1, 32'hF000_0000, 1'b1, 2'b10, 32'h41, 32'h0);
    c_mreq = 1'b0; c_write = 1'b0; c_size = 2'b00;
    check("store.bus_err", 32'(bus_err), 32'd1);

    // Async reset mid data transaction
    c_mreq = 1'b1; c_dad = 32'hFF00_0000;
    @(posedge clk); #1;
    check("arst.m_req_pre", 32'(m_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst.m_req",   32'(m_req),    32'd0);
    check("arst.ackd_n",  32'(c_ackd_n), 32'd1);
    check("arst.bus_err", 32'(bus_err),  32'd0);
    c_mreq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("arst.idle_m_req", 32'(m_req), 32'd0);
    c_ireq = 1'b1; c_iad = 32'h104;
    txn("post_rst", 1'b0, 32'h104, 1'b0, 2'b00, 32'h0, 32'h0000_0013);
    c_ireq = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
